// File: rtl/pipe_adder_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
// Defaults match a 32-bit datapath split into four 8-bit chunks.
package pipe_adder_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 4;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit width_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// One CW-bit chunk of the ripple pipeline: registered partial sum, carry and valid.
// Latency 1 cycle; holds everything when en is low (PIPE_ADDER_OVF_EN adds ovf).
module pipe_adder_stage #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          in_vld,
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          c_in,
    output logic [CW-1:0] sum,
    output logic          c,
`ifdef PIPE_ADDER_OVF_EN
    output logic          ovf,
`endif
    output logic          vld
);

    logic [CW:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, c_in};

    // Data only loads with a valid operation, so bubbles leave the registers untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
            sum <= '0;
            c   <= 1'b0;
        end else if (en) begin
            vld <= in_vld;
            if (in_vld) begin
                sum <= full[CW-1:0];
                c   <= full[CW];
            end
        end
    end

`ifdef PIPE_ADDER_OVF_EN
    // Carry into the MSB is recovered as a^b^sum at that bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (en && in_vld) begin
            ovf <= full[CW] ^ (a[CW-1] ^ b[CW-1] ^ full[CW-1]);
        end
    end
`endif

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/sub, one CW chunk per stage; latency STAGES, one op per cycle.
// Global stall: in_ready_out = out_ready_in | ~out_valid_out; ovf_out with PIPE_ADDER_OVF_EN.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             in_valid_in,
    output logic             in_ready_out,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             sub_in,
    output logic             out_valid_out,
    input  logic             out_ready_in,
    output logic [WIDTH-1:0] sum_out,
`ifdef PIPE_ADDER_OVF_EN
    output logic             ovf_out,
`endif
    output logic             c_out
);

    localparam int CW = chunk_width(WIDTH, STAGES);

    if (!width_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
    end

    logic             en;
    logic [WIDTH-1:0] a_k  [STAGES];
    logic [WIDTH-1:0] b_k  [STAGES];
    logic [WIDTH-1:0] lo_k [STAGES];
    logic             c_k  [STAGES];
    logic             v_k  [STAGES];
    logic [WIDTH-1:0] a_q  [STAGES];
    logic [WIDTH-1:0] b_q  [STAGES];
    logic [WIDTH-1:0] lo_q [STAGES];
    logic [CW-1:0]    st_sum [STAGES];
    logic             st_c   [STAGES];
    logic             st_v   [STAGES];
`ifdef PIPE_ADDER_OVF_EN
    logic             st_ovf [STAGES];
`endif

    assign en           = out_ready_in | ~out_valid_out;
    assign in_ready_out = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // a_k/b_k hold the not-yet-consumed operand chunks shifted down so chunk k sits at bit 0;
        // lo_k collects the finished lower result chunks travelling alongside.
        if (k == 0) begin : g_entry
            assign a_k[k]  = a_in;
            assign b_k[k]  = b_in ^ {WIDTH{sub_in}};
            assign c_k[k]  = sub_in;
            assign v_k[k]  = in_valid_in;
            assign lo_k[k] = '0;
        end else begin : g_link
            assign a_k[k]  = a_q[k-1];
            assign b_k[k]  = b_q[k-1];
            assign c_k[k]  = st_c[k-1];
            assign v_k[k]  = st_v[k-1];
            assign lo_k[k] = lo_q[k-1] | (WIDTH'(st_sum[k-1]) << ((k - 1) * CW));
        end

        if (k < STAGES - 1) begin : g_skew
            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    a_q[k] <= '0;
                    b_q[k] <= '0;
                end else if (en && v_k[k]) begin
                    a_q[k] <= a_k[k] >> CW;
                    b_q[k] <= b_k[k] >> CW;
                end
            end
        end

        always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                lo_q[k] <= '0;
            end else if (en && v_k[k]) begin
                lo_q[k] <= lo_k[k];
            end
        end

        pipe_adder_stage #(.CW(CW)) u_stage (
            .clk    (clk_in),
            .rst_n  (rst_n_in),
            .en     (en),
            .in_vld (v_k[k]),
            .a      (a_k[k][CW-1:0]),
            .b      (b_k[k][CW-1:0]),
            .c_in   (c_k[k]),
            .sum    (st_sum[k]),
            .c      (st_c[k]),
`ifdef PIPE_ADDER_OVF_EN
            .ovf    (st_ovf[k]),
`endif
            .vld    (st_v[k])
        );
    end

    assign sum_out       = lo_q[STAGES-1] | (WIDTH'(st_sum[STAGES-1]) << ((STAGES - 1) * CW));
    assign c_out         = st_c[STAGES-1];
    assign out_valid_out = st_v[STAGES-1];
`ifdef PIPE_ADDER_OVF_EN
    assign ovf_out       = st_ovf[STAGES-1];
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench: 8-bit/2-stage instance for arithmetic, stall and reset cases,
// 32-bit/4-stage instance streamed at full rate under a ready pattern.
module tb_pipe_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    logic       iv8, ir8, ov8, or8, sub8, co8;
    logic [7:0] a8, b8, s8;
    logic        iv32, ir32, ov32, or32, sub32, co32;
    logic [31:0] a32, b32, s32;
`ifdef PIPE_ADDER_OVF_EN
    logic ovf8, ovf32;
    localparam logic [9:0]  MASK8  = 10'h3FF;
    localparam logic [33:0] MASK32 = 34'h3_FFFF_FFFF;
`else
    localparam logic [9:0]  MASK8  = 10'h1FF;
    localparam logic [33:0] MASK32 = 34'h1_FFFF_FFFF;
`endif

    pipe_adder #(.WIDTH(8), .STAGES(2)) u_add8 (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .in_valid_in   (iv8),
        .in_ready_out  (ir8),
        .a_in          (a8),
        .b_in          (b8),
        .sub_in        (sub8),
        .out_valid_out (ov8),
        .out_ready_in  (or8),
        .sum_out       (s8),
`ifdef PIPE_ADDER_OVF_EN
        .ovf_out       (ovf8),
`endif
        .c_out         (co8)
    );

    pipe_adder #(.WIDTH(32), .STAGES(4)) u_add32 (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .in_valid_in   (iv32),
        .in_ready_out  (ir32),
        .a_in          (a32),
        .b_in          (b32),
        .sub_in        (sub32),
        .out_valid_out (ov32),
        .out_ready_in  (or32),
        .sum_out       (s32),
`ifdef PIPE_ADDER_OVF_EN
        .ovf_out       (ovf32),
`endif
        .c_out         (co32)
    );

    // Hand-computed 32-bit vectors: result, carry, signed overflow.
    localparam int N32 = 10;
    logic [31:0] va [N32] = '{32'hFFFFFFFF, 32'h12345678, 32'h0000FFFF, 32'h00000000, 32'h80000000,
                              32'hDEADBEEF, 32'h00FF00FF, 32'hA5A5A5A5, 32'h00000100, 32'h7FFFFFFF};
    logic [31:0] vb [N32] = '{32'h00000001, 32'h11111111, 32'h00000001, 32'h00000001, 32'h00000001,
                              32'hDEADBEEF, 32'h00010001, 32'h5A5A5A5B, 32'h00000200, 32'h00000001};
    logic        vsub [N32] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] vs [N32] = '{32'h00000000, 32'h23456789, 32'h00010000, 32'hFFFFFFFF, 32'h7FFFFFFF,
                              32'h00000000, 32'h01000100, 32'h00000000, 32'hFFFFFF00, 32'h80000000};
    logic        vc [N32] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        vo [N32] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] res8();
`ifdef PIPE_ADDER_OVF_EN
        return {ovf8, co8, s8};
`else
        return {1'b0, co8, s8};
`endif
    endfunction

    function automatic logic [33:0] res32();
`ifdef PIPE_ADDER_OVF_EN
        return {ovf32, co32, s32};
`else
        return {1'b0, co32, s32};
`endif
    endfunction

    // Called just after an edge; operands change after acceptance to prove they are not resampled.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic sub,
                       input logic eo, input logic ec, input logic [7:0] es);
        iv8 = 1'b1; a8 = a; b8 = b; sub8 = sub; or8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0; a8 = 8'hAA; b8 = 8'h55; sub8 = ~sub;
        check({tag, "_lat"}, 64'(ov8), 64'd0);
        @(posedge clk); #1;
        check({tag, "_vld"}, 64'(ov8), 64'd1);
        check({tag, "_res"}, 64'(res8()), 64'({eo, ec, es} & MASK8));
    endtask

    logic        acc, emit;
    logic [33:0] got32;
    logic [15:0] rdy_pat;
    int          in_i, out_i;

    initial begin
        rst_n = 1'b1;
        iv8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; or8 = 1'b1;
        iv32 = 1'b0; a32 = '0; b32 = '0; sub32 = 1'b0; or32 = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_res8", 64'(res8()), 64'd0);
        check("rst_vld8", 64'(ov8), 64'd0);
        check("rst_res32", 64'(res32()), 64'd0);
        check("rst_vld32", 64'(ov32), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("rdy_after_rst", 64'(ir8), 64'd1);

        op8("add_carry", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 8'h00);
        op8("sub_borrow", 8'h05, 8'h07, 1'b1, 1'b0, 1'b0, 8'hFE);
        op8("sub_noborrow", 8'h07, 8'h05, 1'b1, 1'b0, 1'b1, 8'h02);
        op8("add_ovf", 8'h7F, 8'h01, 1'b0, 1'b1, 1'b0, 8'h80);
        op8("add_noovf", 8'h10, 8'h20, 1'b0, 1'b0, 1'b0, 8'h30);
        op8("sub_ovf", 8'h80, 8'h01, 1'b1, 1'b1, 1'b1, 8'h7F);

        // Backpressure: three back-to-back adds, stall three cycles once the first result shows.
        iv8 = 1'b1; a8 = 8'h01; b8 = 8'h01; sub8 = 1'b0; or8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'h02; b8 = 8'h02;
        @(posedge clk); #1;
        a8 = 8'h03; b8 = 8'h03; or8 = 1'b0;
        #1;
        check("bp_first_vld", 64'(ov8), 64'd1);
        check("bp_first_sum", 64'(s8), 64'h02);
        check("bp_rdy_low", 64'(ir8), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold_sum_%0d", i), 64'(s8), 64'h02);
            check($sformatf("bp_hold_rdy_%0d", i), 64'({ov8, ir8}), 64'b10);
        end
        or8 = 1'b1;
        #1;
        check("bp_rdy_back", 64'(ir8), 64'd1);
        @(posedge clk); #1;
        iv8 = 1'b0;
        check("bp_second", 64'({ov8, s8}), 64'h104);
        @(posedge clk); #1;
        check("bp_third", 64'({ov8, s8}), 64'h106);
        @(posedge clk); #1;
        check("bp_drained", 64'(ov8), 64'd0);

        // Reset while two operations are in flight.
        iv8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
        @(posedge clk); #1;
        a8 = 8'h33; b8 = 8'h44;
        @(posedge clk); #1;
        iv8 = 1'b0;
        check("mid_pre_rst", 64'({ov8, s8}), 64'h133);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out", 64'({ov8, co8, s8}), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("mid_no_result_%0d", i), 64'(ov8), 64'd0);
        end

        // Full-rate stream on the 32-bit instance with a rotating ready pattern.
        rdy_pat = 16'b1101_1011_0111_0111;
        in_i = 0;
        out_i = 0;
        for (int cyc = 0; cyc < 200 && out_i < N32; cyc++) begin
            or32 = rdy_pat[0];
            rdy_pat = {rdy_pat[0], rdy_pat[15:1]};
            iv32 = (in_i < N32);
            if (in_i < N32) begin
                a32 = va[in_i]; b32 = vb[in_i]; sub32 = vsub[in_i];
            end
            #1;
            acc   = iv32 && ir32;
            emit  = ov32 && or32;
            got32 = res32();
            @(posedge clk); #1;
            if (acc) in_i++;
            if (emit) begin
                if (out_i < N32)
                    check($sformatf("stream_%0d", out_i), 64'(got32),
                          64'({vo[out_i], vc[out_i], vs[out_i]} & MASK32));
                out_i++;
            end
        end
        iv32 = 1'b0;
        check("stream_count", 64'(out_i), 64'(N32));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
